fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 110 +++++++++++
 tb/tb_fnd_scan_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with blanking gaps between digits.
// Optional leading-zero suppression is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  output logic [1:0]  o_digitPosition,
  output logic [7:0]  o_font,
  output logic        o_frame_tick
);

  localparam int CNT_MAX = ((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC) - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      snap_bcd;
  logic [3:0]       snap_dp;

  function automatic logic [7:0] font_of(input logic [15:0] bcd, input logic [3:0] dp,
                                         input logic [1:0] p);
    logic [3:0] nib;
    logic [6:0] seg;
    logic       blank;
    nib = 4'(bcd >> {p, 2'b00});
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    // A digit is suppressed only if it and every more significant nibble are zero.
    case (p)
      2'd3:    blank = (bcd[15:12] == 4'h0);
      2'd2:    blank = (bcd[15:8] == 8'h00);
      2'd1:    blank = (bcd[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
`endif
    return {~dp[p], blank ? 7'h7F : seg};
  endfunction

  // The font is computed from the post-edge state so it carries no extra latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= BLANK;
      cnt             <= '0;
      o_digitPosition <= 2'd0;
      o_font          <= 8'hFF;
      o_frame_tick    <= 1'b0;
      snap_bcd        <= 16'h0000;
      snap_dp         <= 4'h0;
    end else begin
      o_frame_tick <= 1'b0;
      case (state)
        BLANK: begin
          o_font <= 8'hFF;
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            if (o_digitPosition == 2'd0) begin
              snap_bcd <= i_bcd;
              snap_dp  <= i_dp;
              o_font   <= font_of(i_bcd, i_dp, o_digitPosition);
            end else begin
              o_font   <= font_of(snap_bcd, snap_dp, o_digitPosition);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == SHOW_LAST) begin
            state           <= BLANK;
            cnt             <= '0;
            o_digitPosition <= o_digitPosition + 2'd1;
            o_font          <= 8'hFF;
            o_frame_tick    <= (o_digitPosition == 2'd3);
          end else begin
            cnt    <= cnt + 1'b1;
            o_font <= font_of(snap_bcd, snap_dp, o_digitPosition);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller with SCAN_DIV=8, BLANK_CYC=2.
module tb_fnd_scan_controller;

  logic        clk;
  logic        reset;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [1:0]  o_digitPosition;
  logic [7:0]  o_font;
  logic        o_frame_tick;

  int checkCount;
  int failCount;

  fnd_scan_controller #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_bcd(bcd),
    .i_dp(dp),
    .o_digitPosition(o_digitPosition),
    .o_font(o_font),
    .o_frame_tick(o_frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] newBcd, input logic [3:0] newDp);
    bcd = newBcd;
    dp  = newDp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at frame cycle 0 (first SHOW cycle of digit 0); leaves at cycle 0 of the next frame.
  task automatic checkFrame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                            input logic [7:0] f3, input int chgCycle, input logic [15:0] chgBcd,
                            input logic [3:0] chgDp);
    logic [7:0] fonts [4];
    int d;
    int c;
    fonts = '{f0, f1, f2, f3};
    for (int i = 0; i < 40; i++) begin
      d = i / 10;
      c = i % 10;
      if (c < 8) begin
        checkOutput("showFont", 16'(o_font), 16'(fonts[d]));
        checkOutput("showPos", 16'(o_digitPosition), 16'(d));
      end else begin
        checkOutput("blankFont", 16'(o_font), 16'h00FF);
        checkOutput("blankPos", 16'(o_digitPosition), 16'((d + 1) % 4));
      end
      checkOutput("frameTick", 16'(o_frame_tick), 16'((d == 3) && (c == 8)));
      if (i == chgCycle) applyStimulus(chgBcd, chgDp);
      step();
    end
  endtask

  initial begin
    logic [1:0] prevPos;
    int tickCount;
    checkCount = 0;
    failCount  = 0;
    reset = 1'b1;
    applyStimulus(16'h1234, 4'b0000);
    step();
    step();
    checkOutput("rstFont", 16'(o_font), 16'h00FF);
    checkOutput("rstPos", 16'(o_digitPosition), 16'h0000);
    checkOutput("rstTick", 16'(o_frame_tick), 16'h0000);
    reset = 1'b0;
    step();
    checkOutput("relBlankFont", 16'(o_font), 16'h00FF);
    checkOutput("relBlankPos", 16'(o_digitPosition), 16'h0000);
    step();

    // Input change mid-frame must not tear the current frame.
    checkFrame(8'h99, 8'hB0, 8'hA4, 8'hF9, 15, 16'h5678, 4'b0000);
    checkFrame(8'h80, 8'hF8, 8'h82, 8'h92, 39, 16'h0000, 4'b0100);
`ifdef FND_LEADING_ZERO_BLANK_EN
    checkFrame(8'hC0, 8'hFF, 8'h7F, 8'hFF, 39, 16'h0070, 4'b0000);
    checkFrame(8'hC0, 8'hF8, 8'hFF, 8'hFF, -1, 16'h0000, 4'b0000);
`else
    checkFrame(8'hC0, 8'hC0, 8'h40, 8'hC0, 39, 16'h0070, 4'b0000);
    checkFrame(8'hC0, 8'hF8, 8'hC0, 8'hC0, -1, 16'h0000, 4'b0000);
`endif

    // Three frames of random data: position may only move while the segments are dark.
    prevPos   = o_digitPosition;
    tickCount = 0;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(16'($urandom), 4'($urandom));
      step();
      if (o_frame_tick) tickCount++;
      if (o_digitPosition != prevPos) checkOutput("posChgFont", 16'(o_font), 16'h00FF);
      prevPos = o_digitPosition;
    end
    checkOutput("tickCount", 16'(tickCount), 16'd3);

    repeat (24) step();
    checkOutput("midShowPos", 16'(o_digitPosition), 16'h0002);
    applyStimulus(16'hDCB9, 4'b0001);
    reset = 1'b1;
    #1;
    checkOutput("asyncRstFont", 16'(o_font), 16'h00FF);
    checkOutput("asyncRstPos", 16'(o_digitPosition), 16'h0000);
    checkOutput("asyncRstTick", 16'(o_frame_tick), 16'h0000);
    step();
    checkOutput("heldRstFont", 16'(o_font), 16'h00FF);
    reset = 1'b0;
    step();
    checkOutput("postRstBlankFont", 16'(o_font), 16'h00FF);
    checkOutput("postRstBlankPos", 16'(o_digitPosition), 16'h0000);
    step();
    checkFrame(8'h10, 8'h83, 8'hC6, 8'hA1, -1, 16'h0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
